// File: rtl/lane_collision_ctrl_if.sv
// Bus bundle for lane_collision_ctrl: obstacle/frog geometry and control strobes
// from the game side, and status outputs back from the collision controller.
interface lane_collision_ctrl_if #(
  parameter int N_OBJ = 8,
  parameter int CW    = 12
);
  // No valid/ready pair: i_animate is a one-cycle end-of-frame strobe taken
  // only in PLAY and HIT, i_start is a level sampled every cycle, geometry is
  // plain level data.
  logic                  i_animate;
  logic                  i_start;
  logic [N_OBJ*CW-1:0]   i_obj_x1;
  logic [N_OBJ*CW-1:0]   i_obj_x2;
  logic [N_OBJ*CW-1:0]   i_obj_y1;
  logic [N_OBJ*CW-1:0]   i_obj_y2;
  logic [N_OBJ-1:0]      i_obj_en;
  logic [CW-1:0]         i_frog_x1;
  logic [CW-1:0]         i_frog_x2;
  logic [CW-1:0]         i_frog_y1;
  logic [CW-1:0]         i_frog_y2;
  logic [2:0]            o_state;
  logic                  o_dead;
  logic                  o_game_over;
  logic                  o_respawn;
  logic [3:0]            o_lives;
  logic [7:0]            o_score;
  logic [N_OBJ-1:0]      o_hit_mask;
  logic                  o_overrun;

  modport master (
    output i_animate, i_start, i_obj_x1, i_obj_x2, i_obj_y1, i_obj_y2, i_obj_en,
           i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2,
    input  o_state, o_dead, o_game_over, o_respawn, o_lives, o_score,
           o_hit_mask, o_overrun
  );

  modport slave (
    input  i_animate, i_start, i_obj_x1, i_obj_x2, i_obj_y1, i_obj_y2, i_obj_en,
           i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2,
    output o_state, o_dead, o_game_over, o_respawn, o_lives, o_score,
           o_hit_mask, o_overrun
  );
endinterface

// File: rtl/lane_collision_ctrl.sv
// Frog-versus-obstacle collision controller: scans one obstacle per cycle after
// each frame strobe, then updates lives, score and respawn/game-over status.
module lane_collision_ctrl #(
  parameter int N_OBJ      = 8,
  parameter int CW         = 12,
  parameter int LIVES      = 3,
  parameter int HIT_FRAMES = 60,
  parameter int GOAL_Y     = 30
) (
  input logic                i_clk,
  input logic                i_rst_n,
  lane_collision_ctrl_if.slave bus
);
  localparam int            IW        = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_OBJ - 1);
  localparam logic [3:0]    LIVES_C   = 4'(LIVES);
  localparam logic [7:0]    FRAMES_C  = 8'(HIT_FRAMES);
  localparam logic [CW-1:0] GOAL_C    = CW'(GOAL_Y);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    SCAN   = 3'd2,
    DECIDE = 3'd3,
    HIT    = 3'd4,
    OVER   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    fx1_q, fx2_q, fy1_q, fy2_q;
  logic [CW-1:0]    fx1_d, fx2_d, fy1_d, fy2_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_OBJ-1:0] mask_q, mask_d;
  logic [N_OBJ-1:0] hit_mask_q, hit_mask_d;
  logic [7:0]       frame_q, frame_d;
  logic [3:0]       lives_q, lives_d;
  logic [7:0]       score_q, score_d;
  logic             overrun_q, overrun_d;
  logic             respawn_q, respawn_d;
  logic             dead_q, dead_d;
  logic             over_q, over_d;

  logic [CW-1:0]    ox1, ox2, oy1, oy2;
  logic             oen, hit_now;

  // Object coordinates are sampled live, so the mux reads the bus directly.
  always_comb begin
    ox1 = '0;
    ox2 = '0;
    oy1 = '0;
    oy2 = '0;
    oen = 1'b0;
    for (int k = 0; k < N_OBJ; k++) begin
      if (idx_q == IW'(k)) begin
        ox1 = bus.i_obj_x1[k*CW +: CW];
        ox2 = bus.i_obj_x2[k*CW +: CW];
        oy1 = bus.i_obj_y1[k*CW +: CW];
        oy2 = bus.i_obj_y2[k*CW +: CW];
        oen = bus.i_obj_en[k];
      end
    end
  end

  assign hit_now = oen && (fx1_q < ox2) && (fx2_q > ox1) &&
                   (fy1_q < oy2) && (fy2_q > oy1);

  always_comb begin
    state_d    = state_q;
    fx1_d      = fx1_q;
    fx2_d      = fx2_q;
    fy1_d      = fy1_q;
    fy2_d      = fy2_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    hit_mask_d = hit_mask_q;
    frame_d    = frame_q;
    lives_d    = lives_q;
    score_d    = score_q;
    overrun_d  = overrun_q;
    respawn_d  = 1'b0;
    case (state_q)
      IDLE: begin
        lives_d = LIVES_C;
        score_d = '0;
        if (bus.i_start) state_d = PLAY;
      end
      PLAY: begin
        if (bus.i_animate) begin
          fx1_d   = bus.i_frog_x1;
          fx2_d   = bus.i_frog_x2;
          fy1_d   = bus.i_frog_y1;
          fy2_d   = bus.i_frog_y2;
          mask_d  = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit_now) mask_d[idx_q] = 1'b1;
        if (idx_q == IDX_LAST) state_d = DECIDE;
        else                   idx_d   = idx_q + 1'b1;
        if (bus.i_animate) overrun_d = 1'b1;
      end
      DECIDE: begin
        hit_mask_d = mask_q;
        state_d    = PLAY;
        if (bus.i_animate) overrun_d = 1'b1;
        // A collision outranks reaching the goal in the same frame.
        if (|mask_q) begin
          if (lives_q <= 4'd1) begin
            lives_d = '0;
            state_d = OVER;
          end else begin
            lives_d = lives_q - 4'd1;
            frame_d = FRAMES_C;
            state_d = HIT;
          end
        end else if (fy1_q <= GOAL_C) begin
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          respawn_d = 1'b1;
        end
      end
      HIT: begin
        if (bus.i_animate) begin
          if (frame_q <= 8'd1) begin
            frame_d   = '0;
            respawn_d = 1'b1;
            state_d   = PLAY;
          end else begin
            frame_d = frame_q - 8'd1;
          end
        end
      end
      OVER: begin
        if (bus.i_start) begin
          lives_d    = LIVES_C;
          score_d    = '0;
          hit_mask_d = '0;
          state_d    = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase
    dead_d = (state_d == HIT) || (state_d == OVER);
    over_d = (state_d == OVER);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      fx1_q      <= '0;
      fx2_q      <= '0;
      fy1_q      <= '0;
      fy2_q      <= '0;
      idx_q      <= '0;
      mask_q     <= '0;
      hit_mask_q <= '0;
      frame_q    <= '0;
      lives_q    <= LIVES_C;
      score_q    <= '0;
      overrun_q  <= 1'b0;
      respawn_q  <= 1'b0;
      dead_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fx1_q      <= fx1_d;
      fx2_q      <= fx2_d;
      fy1_q      <= fy1_d;
      fy2_q      <= fy2_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      hit_mask_q <= hit_mask_d;
      frame_q    <= frame_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      overrun_q  <= overrun_d;
      respawn_q  <= respawn_d;
      dead_q     <= dead_d;
      over_q     <= over_d;
    end
  end

  assign bus.o_state     = state_q;
  assign bus.o_dead      = dead_q;
  assign bus.o_game_over = over_q;
  assign bus.o_respawn   = respawn_q;
  assign bus.o_lives     = lives_q;
  assign bus.o_score     = score_q;
  assign bus.o_hit_mask  = hit_mask_q;
  assign bus.o_overrun   = overrun_q;
endmodule

// File: tb/tb_lane_collision_ctrl.sv
// Bench for lane_collision_ctrl: a frame-level game model predicts every output
// each cycle; randomized geometry, live object changes and overrun strobes.
module tb_lane_collision_ctrl;
  localparam int N_OBJ      = 8;
  localparam int CW         = 12;
  localparam int LIVES      = 3;
  localparam int HIT_FRAMES = 3;
  localparam int GOAL_Y     = 30;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lane_collision_ctrl_if #(.N_OBJ(N_OBJ), .CW(CW)) bus ();

  lane_collision_ctrl #(
    .N_OBJ(N_OBJ), .CW(CW), .LIVES(LIVES), .HIT_FRAMES(HIT_FRAMES), .GOAL_Y(GOAL_Y)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  logic [CW-1:0]    ox1 [N_OBJ];
  logic [CW-1:0]    ox2 [N_OBJ];
  logic [CW-1:0]    oy1 [N_OBJ];
  logic [CW-1:0]    oy2 [N_OBJ];
  logic [N_OBJ-1:0] oen;

  for (genvar g = 0; g < N_OBJ; g++) begin : g_pack
    assign bus.i_obj_x1[g*CW +: CW] = ox1[g];
    assign bus.i_obj_x2[g*CW +: CW] = ox2[g];
    assign bus.i_obj_y1[g*CW +: CW] = oy1[g];
    assign bus.i_obj_y2[g*CW +: CW] = oy2[g];
  end
  assign bus.i_obj_en = oen;

  // ---------------- model state ----------------
  int               exp_state = 0;
  logic [3:0]       exp_lives = 4'(LIVES);
  logic [7:0]       exp_score = 8'd0;
  logic [N_OBJ-1:0] exp_mask  = '0;
  bit               exp_ovr   = 1'b0;
  bit               exp_resp  = 1'b0;
  int               m_frames  = 0;
  logic [CW-1:0]    mfx1, mfx2, mfy1, mfy2;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("state",     32'(bus.o_state),     32'(exp_state));
    check("lives",     32'(bus.o_lives),     32'(exp_lives));
    check("score",     32'(bus.o_score),     32'(exp_score));
    check("hit_mask",  32'(bus.o_hit_mask),  32'(exp_mask));
    check("overrun",   32'(bus.o_overrun),   32'(exp_ovr));
    check("respawn",   32'(bus.o_respawn),   32'(exp_resp));
    check("dead",      32'(bus.o_dead),      32'((exp_state == 4) || (exp_state == 5)));
    check("game_over", 32'(bus.o_game_over), 32'(exp_state == 5));
  endtask

  always @(negedge clk) if (chk_en) compare_all();

  // ---------------- model helpers ----------------
  function automatic bit ovl(input int k);
    return oen[k] && (mfx1 < ox2[k]) && (mfx2 > ox1[k]) &&
           (mfy1 < oy2[k]) && (mfy2 > oy1[k]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    exp_resp = 1'b0;
  endtask

  task automatic set_frog(input int x1, input int y1, input int x2, input int y2);
    bus.i_frog_x1 = CW'(x1);
    bus.i_frog_y1 = CW'(y1);
    bus.i_frog_x2 = CW'(x2);
    bus.i_frog_y2 = CW'(y2);
  endtask

  task automatic rand_frog();
    int x, y;
    x = $urandom_range(0, 1000);
    y = $urandom_range(0, 200);
    set_frog(x, y, x + $urandom_range(1, 60), y + $urandom_range(1, 40));
  endtask

  task automatic set_obj(input int k, input int x1, input int y1, input int x2,
                         input int y2, input bit en);
    ox1[k] = CW'(x1);
    oy1[k] = CW'(y1);
    ox2[k] = CW'(x2);
    oy2[k] = CW'(y2);
    oen[k] = en;
  endtask

  task automatic objs_off();
    for (int k = 0; k < N_OBJ; k++) set_obj(k, 3000, 3000, 3001, 3001, 1'b0);
  endtask

  // Random boxes, some placed exactly touching the captured frog edges.
  task automatic rand_objs();
    int x, y;
    for (int k = 0; k < N_OBJ; k++) begin
      x = $urandom_range(0, 1000);
      y = $urandom_range(0, 200);
      set_obj(k, x, y, x + $urandom_range(1, 400), y + $urandom_range(1, 100),
              $urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: begin ox1[k] = mfx2; ox2[k] = mfx2 + CW'(50); end
        1: begin ox2[k] = mfx1; ox1[k] = (mfx1 > 10) ? mfx1 - CW'(10) : '0; end
        2: begin oy1[k] = mfy1; oy2[k] = mfy2; ox1[k] = mfx1; ox2[k] = mfx2; end
        default: ;
      endcase
    end
  endtask

  task automatic start_game();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    if (exp_state == 5) begin
      exp_lives = 4'(LIVES);
      exp_score = 8'd0;
      exp_mask  = '0;
    end
    if (exp_state == 0 || exp_state == 5) exp_state = 1;
  endtask

  // One frame from PLAY: capture, N_OBJ scan cycles, one decide cycle.
  task automatic run_frame(input bit live_rand, input bit ovr_en);
    logic [N_OBJ-1:0] m_mask;
    bit ovr_now;
    mfx1 = bus.i_frog_x1;
    mfx2 = bus.i_frog_x2;
    mfy1 = bus.i_frog_y1;
    mfy2 = bus.i_frog_y2;
    bus.i_animate = 1'b1;
    step();
    bus.i_animate = 1'b0;
    exp_state = 2;
    m_mask = '0;
    for (int j = 0; j < N_OBJ; j++) begin
      if (live_rand) begin
        rand_objs();
        rand_frog();
        bus.i_start = 1'($urandom_range(0, 1));
      end
      if (ovr_en && $urandom_range(0, 7) == 0) bus.i_animate = 1'b1;
      if (ovl(j)) m_mask[j] = 1'b1;
      ovr_now = bus.i_animate;
      step();
      bus.i_animate = 1'b0;
      if (ovr_now) exp_ovr = 1'b1;
      exp_state = (j == N_OBJ - 1) ? 3 : 2;
    end
    bus.i_start = 1'b0;
    if (ovr_en && $urandom_range(0, 3) == 0) bus.i_animate = 1'b1;
    ovr_now = bus.i_animate;
    step();
    bus.i_animate = 1'b0;
    if (ovr_now) exp_ovr = 1'b1;
    exp_mask = m_mask;
    if (m_mask != '0) begin
      if (exp_lives == 4'd1) begin
        exp_lives = 4'd0;
        exp_state = 5;
      end else begin
        exp_lives = exp_lives - 4'd1;
        m_frames  = HIT_FRAMES;
        exp_state = 4;
      end
    end else begin
      if (mfy1 <= CW'(GOAL_Y)) begin
        if (exp_score != 8'd255) exp_score = exp_score + 8'd1;
        exp_resp = 1'b1;
      end
      exp_state = 1;
    end
  endtask

  // Strobes through HIT with random gaps; i_start wiggles and must be ignored.
  task automatic run_hit();
    while (exp_state == 4) begin
      repeat ($urandom_range(0, 2)) begin
        bus.i_start = 1'($urandom_range(0, 1));
        step();
      end
      bus.i_start   = 1'b0;
      bus.i_animate = 1'b1;
      step();
      bus.i_animate = 1'b0;
      m_frames--;
      if (m_frames == 0) begin
        exp_state = 1;
        exp_resp  = 1'b1;
      end
    end
  endtask

  task automatic play_idle();
    repeat ($urandom_range(0, 2)) begin
      bus.i_start = 1'($urandom_range(0, 1));
      step();
    end
    bus.i_start = 1'b0;
  endtask

  task automatic advance(input bit ovr_en);
    case (exp_state)
      1: begin
        play_idle();
        rand_frog();
        mfx1 = bus.i_frog_x1; mfx2 = bus.i_frog_x2;
        mfy1 = bus.i_frog_y1; mfy2 = bus.i_frog_y2;
        rand_objs();
        run_frame(1'b1, ovr_en);
      end
      4: run_hit();
      default: start_game();
    endcase
  endtask

  task automatic reset_model();
    exp_state = 0;
    exp_lives = 4'(LIVES);
    exp_score = 8'd0;
    exp_mask  = '0;
    exp_ovr   = 1'b0;
    exp_resp  = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    bus.i_animate = 1'b0;
    bus.i_start   = 1'b0;
    set_frog(300, 400, 340, 440);
    objs_off();
    mfx1 = '0; mfx2 = '0; mfy1 = '0; mfy2 = '0;
    chk_en = 1'b1;
    #12 rst_n = 1'b1;
    check("lit_reset_state", 32'(bus.o_state), 32'd0);
    check("lit_reset_lives", 32'(bus.o_lives), 32'd3);

    // IDLE ignores frame strobes; only i_start leaves it.
    bus.i_animate = 1'b1;
    step();
    bus.i_animate = 1'b0;
    step();
    start_game();

    // No overlap: everything in the y 30-60 band, frog far below.
    for (int k = 0; k < N_OBJ; k++) set_obj(k, k * 100, 30, k * 100 + 350, 60, 1'b1);
    run_frame(1'b0, 1'b0);
    check("lit_noovl_state", 32'(bus.o_state), 32'd1);
    check("lit_noovl_mask", 32'(bus.o_hit_mask), 32'h00);
    check("lit_noovl_lives", 32'(bus.o_lives), 32'd3);

    // Edge touch then one-unit overlap on object 5.
    objs_off();
    set_obj(5, 200, 390, 300, 450, 1'b1);
    run_frame(1'b0, 1'b0);
    check("lit_touch_mask", 32'(bus.o_hit_mask), 32'h00);
    ox2[5] = CW'(301);
    run_frame(1'b0, 1'b0);
    check("lit_hit_mask", 32'(bus.o_hit_mask), 32'h20);
    check("lit_hit_lives", 32'(bus.o_lives), 32'd2);
    check("lit_hit_state", 32'(bus.o_state), 32'd4);
    check("lit_hit_dead", 32'(bus.o_dead), 32'd1);

    // HIT: third strobe respawns for exactly one cycle, fourth scans.
    run_hit();
    check("lit_respawn_hi", 32'(bus.o_respawn), 32'd1);
    check("lit_respawn_state", 32'(bus.o_state), 32'd1);
    step();
    check("lit_respawn_lo", 32'(bus.o_respawn), 32'd0);
    objs_off();
    run_frame(1'b0, 1'b0);

    // Randomized play without overrun strobes.
    for (int i = 0; i < 40; i++) advance(1'b0);

    // Goal crossings until the score saturates.
    for (int i = 0; i < 20 && exp_state != 1; i++) advance(1'b0);
    objs_off();
    set_frog(500, 30, 540, 50);
    repeat (258) run_frame(1'b0, 1'b0);
    check("lit_score_sat", 32'(bus.o_score), 32'd255);

    // Goal and hit together: life lost, score untouched.
    set_obj(0, 0, 0, 4000, 4000, 1'b1);
    run_frame(1'b0, 1'b0);
    check("lit_goalhit_score", 32'(bus.o_score), 32'd255);
    check("lit_goalhit_resp", 32'(bus.o_respawn), 32'd0);

    // Keep getting hit until game over, then restart.
    for (int i = 0; i < 20 && exp_state != 5; i++) begin
      if (exp_state == 4) run_hit();
      else run_frame(1'b0, 1'b0);
    end
    check("lit_over_flag", 32'(bus.o_game_over), 32'd1);
    check("lit_over_lives", 32'(bus.o_lives), 32'd0);
    repeat (3) step();
    start_game();
    check("lit_restart_lives", 32'(bus.o_lives), 32'd3);
    check("lit_restart_score", 32'(bus.o_score), 32'd0);
    check("lit_restart_state", 32'(bus.o_state), 32'd1);

    // Lose a life and score once so the reset has something to clear.
    run_frame(1'b0, 1'b0);
    run_hit();
    objs_off();
    run_frame(1'b0, 1'b0);

    // Overrun at T+3 of a scan, asynchronous reset during T+5.
    mfx1 = bus.i_frog_x1; mfx2 = bus.i_frog_x2;
    mfy1 = bus.i_frog_y1; mfy2 = bus.i_frog_y2;
    bus.i_animate = 1'b1;
    step();
    bus.i_animate = 1'b0;
    exp_state = 2;
    step();
    step();
    bus.i_animate = 1'b1;
    step();
    bus.i_animate = 1'b0;
    exp_ovr = 1'b1;
    check("lit_overrun", 32'(bus.o_overrun), 32'd1);
    step();
    #2;
    reset_model();
    rst_n = 1'b0;
    #1;
    check("lit_async_state", 32'(bus.o_state), 32'd0);
    check("lit_async_lives", 32'(bus.o_lives), 32'd3);
    check("lit_async_score", 32'(bus.o_score), 32'd0);
    check("lit_async_ovr", 32'(bus.o_overrun), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // After reset, strobes alone do nothing until i_start.
    bus.i_animate = 1'b1;
    step();
    bus.i_animate = 1'b0;
    step();
    start_game();

    // Randomized play with overrun strobes in SCAN and DECIDE.
    for (int i = 0; i < 40; i++) advance(1'b1);

    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lane_collision_ctrl.md
LANE_COLLISION_CTRL -- requirements
Module: lane_collision_ctrl

Interface
REQ-001 Parameter N_OBJ, default 8, number of obstacle boxes checked per frame (1-32).
REQ-002 Parameter CW, default 12, coordinate width in bits.
REQ-003 Parameter LIVES, default 3, lives loaded at game start (1-15).
REQ-004 Parameter HIT_FRAMES, default 60, frames spent in HIT before respawn (1-255).
REQ-005 Parameter GOAL_Y, default 30, frog_y1 at or below which a crossing scores.
REQ-006 i_clk  in  1  system clock; all state changes on rising edge.
REQ-007 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 i_animate  in  1  one-cycle end-of-frame strobe.
REQ-009 i_start  in  1  start/restart request, level sampled each cycle.
REQ-010 i_obj_x1, i_obj_x2, i_obj_y1, i_obj_y2  in  N_OBJ*CW each  flattened obstacle box bounds; object k occupies bits [k*CW +: CW].
REQ-011 i_obj_en  in  N_OBJ  per-object enable; disabled objects never collide.
REQ-012 i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2  in  CW each  frog box bounds.
REQ-013 o_state  out  3  FSM state: IDLE=0, PLAY=1, SCAN=2, DECIDE=3, HIT=4, OVER=5.
REQ-014 o_dead  out  1  high in HIT and OVER.
REQ-015 o_game_over  out  1  high in OVER only.
REQ-016 o_respawn  out  1  one-cycle pulse requesting frog return to start.
REQ-017 o_lives  out  4  remaining lives.
REQ-018 o_score  out  8  successful crossings, saturating at 255.
REQ-019 o_hit_mask  out  N_OBJ  objects hit in the last completed scan.
REQ-020 o_overrun  out  1  sticky flag: i_animate arrived during SCAN or DECIDE.

Function
REQ-021 Overlap test (unsigned, strict): frog_x1 < obj_x2 AND frog_x2 > obj_x1 AND frog_y1 < obj_y2 AND frog_y2 > obj_y1 AND i_obj_en[k]; touching edges do not collide.
REQ-022 IDLE: o_lives = LIVES, o_score = 0; i_start high -> PLAY next cycle.
REQ-023 PLAY: on i_animate, capture all frog coordinates into registers, clear the scan mask, set the index to 0, and go to SCAN.
REQ-024 Object inputs are not captured; the object coordinates are sampled live on each SCAN cycle.
REQ-025 SCAN: test object at index idx, one object per cycle, and set mask bit idx on overlap; after idx = N_OBJ-1 go to DECIDE; the scan occupies exactly N_OBJ cycles.
REQ-026 DECIDE (1 cycle): copy the scan mask to o_hit_mask, then:
- mask nonzero and o_lives = 1 -> o_lives = 0, OVER.
- mask nonzero and o_lives > 1 -> o_lives decrements, frame counter loads HIT_FRAMES, HIT.
- mask zero and captured frog_y1 <= GOAL_Y -> o_score increments (saturating), o_respawn pulses, PLAY.
- otherwise -> PLAY.
REQ-027 Collision takes priority over goal when both hold.
REQ-028 HIT: each i_animate decrements the frame counter; the strobe that takes it 1->0 pulses o_respawn and returns to PLAY; that strobe does not start a scan.
REQ-029 OVER: hold all outputs; i_start high -> o_lives = LIVES, o_score = 0, o_hit_mask = 0, PLAY.
REQ-030 i_start is ignored in PLAY, SCAN, DECIDE and HIT.
REQ-031 i_animate during SCAN or DECIDE is dropped and sets o_overrun; o_overrun clears only on reset.
REQ-032 Latency: capture strobe at cycle T -> decision registered at T+N_OBJ+2 (o_hit_mask, o_lives, o_state updated).
REQ-033 Outputs are registered and hold no combinational path from the inputs.

Reset
REQ-034 i_rst_n low asynchronously forces: state IDLE, o_dead 0, o_game_over 0, o_respawn 0, o_lives LIVES, o_score 0, o_hit_mask 0, o_overrun 0, index 0, frame counter 0.
REQ-035 Reset asserted mid-SCAN or mid-HIT abandons the operation with no partial life or score update.
REQ-036 Leaving reset requires i_start to reach PLAY.

Verification
REQ-037 No overlap: N_OBJ=8, frog (300,400)-(340,440), all objects at y 30-60, start then one i_animate -> o_hit_mask 0, o_lives 3, state back to PLAY at T+10.
REQ-038 Edge touch vs overlap: object 5 x2 = 300 -> no hit; then x2 = 301 -> o_hit_mask = 8'h20, o_lives 2, HIT, o_dead 1.
REQ-039 HIT timing: HIT_FRAMES=3, after a hit apply 3 strobes -> o_respawn pulses exactly one cycle on the 3rd strobe, then PLAY; a 4th strobe starts a new scan.
REQ-040 Game over and restart: LIVES=1, a hit leads to OVER with o_game_over 1 and o_lives 0; i_start -> o_lives 1, o_score 0, PLAY.
REQ-041 Goal plus score saturation: frog_y1 = 30 with no hit, repeated 256 times -> o_score 255 with o_respawn pulsing each time; with a simultaneous hit -> life lost and score unchanged.
REQ-042 Overrun and reset: i_animate at T+3 of a scan sets o_overrun; i_rst_n low at T+5 -> all outputs are at reset values immediately, without waiting for a clock edge.
